// File: rtl/gpu_pkg.sv
// ============================================================================
// Module      : gpu_pkg
// Description : Shared constants, opcodes and FSM state type for the GPU
//               shared-memory path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package gpu_pkg;

    localparam int SM_ADDR_W = 12;
    localparam int SM_DATA_W = 8;
    localparam int N_CORES   = 16;

    // Opcodes are shared with the core's memory stage.
    localparam logic [3:0] LD = 4'hB;
    localparam logic [3:0] ST = 4'hD;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        ACK  = 2'd2
    } sm_state_t;

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin pick: first request at or after ptr.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
    parameter int N_REQ = 16,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_valid
);

    localparam logic [IDX_W:0] C_N_EXT = (IDX_W+1)'(N_REQ);

    logic [IDX_W:0]   w_sum;
    logic [IDX_W-1:0] w_idx;

    // Scan from the farthest offset down so the nearest request wins last.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        w_sum       = '0;
        w_idx       = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            w_sum = {1'b0, ptr} + (IDX_W+1)'(i);
            if (w_sum >= C_N_EXT) begin
                w_sum = w_sum - C_N_EXT;
            end
            w_idx = w_sum[IDX_W-1:0];
            if (req[w_idx]) begin
                grant_valid = 1'b1;
                grant_idx   = w_idx;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/shared_mem_arbiter.sv
// ============================================================================
// Module      : shared_mem_arbiter
// Description : Round-robin arbiter of per-core load/store requests plus a
//               low-priority host port onto a single-port shared-memory array.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module shared_mem_arbiter #(
    parameter int N_CORES = gpu_pkg::N_CORES,
    parameter int ADDR_W  = gpu_pkg::SM_ADDR_W,
    parameter int DATA_W  = gpu_pkg::SM_DATA_W
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [N_CORES-1:0]          mem_req_ld,
    input  logic [N_CORES-1:0]          mem_req_st,
    input  logic [N_CORES*ADDR_W-1:0]   addr_shared_memory,
    input  logic [N_CORES*DATA_W-1:0]   mem_dat_st,
    output logic [N_CORES-1:0]          val_data,
    output logic [DATA_W-1:0]           mem_dat,
    input  logic                        host_req,
    input  logic                        host_we,
    input  logic [ADDR_W-1:0]           host_addr,
    input  logic [DATA_W-1:0]           host_wdata,
    output logic [DATA_W-1:0]           host_rdata,
    output logic                        host_ack
);

    import gpu_pkg::*;

    localparam int IDX_W = $clog2(N_CORES);

    sm_state_t          r_state;
    logic [IDX_W-1:0]   r_rr_ptr;
    logic [IDX_W-1:0]   r_gnt_idx;
    logic               r_gnt_host;
    logic [3:0]         r_op;
    logic [ADDR_W-1:0]  r_addr;
    logic [DATA_W-1:0]  r_wdata;
    logic               r_mask_valid;
    logic [IDX_W-1:0]   r_mask_idx;

    logic [N_CORES-1:0] w_mask;
    logic [N_CORES-1:0] w_eligible;
    logic [IDX_W-1:0]   w_gnt_idx;
    logic               w_gnt_valid;

    logic [DATA_W-1:0]  r_mem [2**ADDR_W];

    // The core just acknowledged may still show its request on the first
    // IDLE cycle; hide it so it is not served twice.
    always_comb begin
        w_mask = '0;
        if (r_mask_valid) begin
            w_mask[r_mask_idx] = 1'b1;
        end
        w_eligible = (mem_req_ld | mem_req_st) & ~w_mask;
    end

    rr_arbiter #(
        .N_REQ (N_CORES),
        .IDX_W (IDX_W)
    ) u_rr_arbiter (
        .req         (w_eligible),
        .ptr         (r_rr_ptr),
        .grant_idx   (w_gnt_idx),
        .grant_valid (w_gnt_valid)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_rr_ptr     <= '0;
            r_gnt_idx    <= '0;
            r_gnt_host   <= 1'b0;
            r_op         <= LD;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_mask_valid <= 1'b0;
            r_mask_idx   <= '0;
            val_data     <= '0;
            mem_dat      <= '0;
            host_rdata   <= '0;
            host_ack     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_mask_valid <= 1'b0;
                    if (w_gnt_valid) begin
                        r_gnt_host <= 1'b0;
                        r_gnt_idx  <= w_gnt_idx;
                        r_op       <= mem_req_ld[w_gnt_idx] ? LD : ST;
                        r_addr     <= addr_shared_memory[w_gnt_idx*ADDR_W +: ADDR_W];
                        r_wdata    <= mem_dat_st[w_gnt_idx*DATA_W +: DATA_W];
                        r_state    <= ACC;
                    end else if (host_req) begin
                        r_gnt_host <= 1'b1;
                        r_op       <= host_we ? ST : LD;
                        r_addr     <= host_addr;
                        r_wdata    <= host_wdata;
                        r_state    <= ACC;
                    end
                end
                ACC: begin
                    if (r_op == LD) begin
                        if (r_gnt_host) begin
                            host_rdata <= r_mem[r_addr];
                        end else begin
                            mem_dat <= r_mem[r_addr];
                        end
                    end
                    if (r_gnt_host) begin
                        host_ack <= 1'b1;
                    end else begin
                        val_data[r_gnt_idx] <= 1'b1;
                    end
                    r_state <= ACK;
                end
                ACK: begin
                    val_data <= '0;
                    host_ack <= 1'b0;
                    if (!r_gnt_host) begin
                        r_rr_ptr     <= (r_gnt_idx == IDX_W'(N_CORES - 1)) ? '0 : r_gnt_idx + 1'b1;
                        r_mask_valid <= 1'b1;
                        r_mask_idx   <= r_gnt_idx;
                    end
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Write port; a reset during ACC forces IDLE, so an aborted store never lands.
    always_ff @(posedge clk) begin
        if (r_state == ACC && r_op == ST) begin
            r_mem[r_addr] <= r_wdata;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_shared_mem_arbiter.sv
// ============================================================================
// Module      : tb_shared_mem_arbiter
// Description : Directed scoreboard bench for shared_mem_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_shared_mem_arbiter;

    localparam int NC = 16;
    localparam int AW = 12;
    localparam int DW = 8;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [NC-1:0]     mem_req_ld = '0;
    logic [NC-1:0]     mem_req_st = '0;
    logic [NC*AW-1:0]  addr_shared_memory = '0;
    logic [NC*DW-1:0]  mem_dat_st = '0;
    logic [NC-1:0]     val_data;
    logic [DW-1:0]     mem_dat;
    logic              host_req = 1'b0;
    logic              host_we = 1'b0;
    logic [AW-1:0]     host_addr = '0;
    logic [DW-1:0]     host_wdata = '0;
    logic [DW-1:0]     host_rdata;
    logic              host_ack;

    shared_mem_arbiter dut (
        .clk                (clk),
        .reset              (reset),
        .mem_req_ld         (mem_req_ld),
        .mem_req_st         (mem_req_st),
        .addr_shared_memory (addr_shared_memory),
        .mem_dat_st         (mem_dat_st),
        .val_data           (val_data),
        .mem_dat            (mem_dat),
        .host_req           (host_req),
        .host_we            (host_we),
        .host_addr          (host_addr),
        .host_wdata         (host_wdata),
        .host_rdata         (host_rdata),
        .host_ack           (host_ack)
    );

    typedef struct {
        string       tag;
        logic        is_host;
        logic [15:0] vd;
        logic [7:0]  data;
        logic        chk;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    logic [7:0]  obs;
    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    logic [15:0] rel1 = '0;
    logic [15:0] rel2 = '0;
    logic [15:0] hold_mask = '0;
    logic        host_rel = 1'b0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: every acknowledge pops one expected entry.
    always @(negedge clk) begin
        if (reset && (val_data != '0 || host_ack)) begin
            vectors++;
            assert (sb.size() != 0) else begin
                miscompares++;
                $error("FAIL unexpected_ack: observed val_data=%h host_ack=%b expected no acknowledge", val_data, host_ack);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                vectors++;
                assert (val_data === e.vd) else begin
                    miscompares++;
                    $error("FAIL %s val_data: observed %h expected %h", e.tag, val_data, e.vd);
                end
                vectors++;
                assert (host_ack === e.is_host) else begin
                    miscompares++;
                    $error("FAIL %s host_ack: observed %b expected %b", e.tag, host_ack, e.is_host);
                end
                vectors++;
                assert (cyc === e.cyc) else begin
                    miscompares++;
                    $error("FAIL %s cycle: observed %0d expected %0d", e.tag, cyc, e.cyc);
                end
                if (e.chk) begin
                    obs = e.is_host ? host_rdata : mem_dat;
                    vectors++;
                    assert (obs === e.data) else begin
                        miscompares++;
                        $error("FAIL %s data: observed %h expected %h", e.tag, obs, e.data);
                    end
                end
            end
        end
    end

    // Advance one cycle, then release requests the way a core/host would:
    // on the edge that ends the acknowledge (or one cycle later if held).
    task automatic tick();
        logic [15:0] drop;
        @(posedge clk);
        #1;
        drop = (rel1 & ~hold_mask) | rel2;
        mem_req_ld = mem_req_ld & ~drop;
        mem_req_st = mem_req_st & ~drop;
        rel2 = rel1 & hold_mask;
        rel1 = val_data;
        if (host_rel) host_req = 1'b0;
        host_rel = host_ack;
    endtask

    task automatic core_req(input int k, input bit ld, input logic [11:0] a, input logic [7:0] d);
        addr_shared_memory[k*AW +: AW] = a;
        mem_dat_st[k*DW +: DW] = d;
        if (ld) mem_req_ld[k] = 1'b1;
        else    mem_req_st[k] = 1'b1;
    endtask

    task automatic host_go(input bit we, input logic [11:0] a, input logic [7:0] d);
        host_we    = we;
        host_addr  = a;
        host_wdata = d;
        host_req   = 1'b1;
    endtask

    task automatic expect_ev(input string tag, input bit is_host, input logic [15:0] vd,
                             input logic [7:0] data, input bit chk, input int dc);
        exp_t x;
        x.tag = tag; x.is_host = is_host; x.vd = vd;
        x.data = data; x.chk = chk; x.cyc = cyc + dc;
        sb.push_back(x);
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 60) begin
            tick();
            n++;
        end
        repeat (4) tick();
        vectors++;
        assert (sb.size() == 0) else begin
            miscompares++;
            $error("FAIL %s timeout: observed %0d pending expected 0", tag, sb.size());
            sb.delete();
        end
    endtask

    task automatic check_zero(input string tag);
        vectors++;
        assert (val_data === '0) else begin
            miscompares++; $error("FAIL %s val_data: observed %h expected 0", tag, val_data);
        end
        vectors++;
        assert (mem_dat === '0) else begin
            miscompares++; $error("FAIL %s mem_dat: observed %h expected 0", tag, mem_dat);
        end
        vectors++;
        assert (host_ack === 1'b0) else begin
            miscompares++; $error("FAIL %s host_ack: observed %b expected 0", tag, host_ack);
        end
        vectors++;
        assert (host_rdata === '0) else begin
            miscompares++; $error("FAIL %s host_rdata: observed %h expected 0", tag, host_rdata);
        end
    endtask

    initial begin
        repeat (2) tick();
        check_zero("reset");
        reset = 1'b1;
        tick();

        // Host write then read-back
        host_go(1'b1, 12'h123, 8'h5A); expect_ev("host_wr", 1'b1, '0, 8'h00, 1'b0, 2); drain("host_wr");
        host_go(1'b0, 12'h123, 8'h00); expect_ev("host_rd", 1'b1, '0, 8'h5A, 1'b1, 2); drain("host_rd");

        // Preload for simultaneous loads
        host_go(1'b1, 12'h100, 8'hA0); expect_ev("pre0", 1'b1, '0, 8'h00, 1'b0, 2); drain("pre0");
        host_go(1'b1, 12'h105, 8'hA5); expect_ev("pre5", 1'b1, '0, 8'h00, 1'b0, 2); drain("pre5");
        host_go(1'b1, 12'h10F, 8'hAF); expect_ev("pre15", 1'b1, '0, 8'h00, 1'b0, 2); drain("pre15");

        // Two rounds of cores 0, 5, 15 loading together
        for (int r = 0; r < 2; r++) begin
            core_req(0, 1'b1, 12'h100, 8'h00);
            core_req(5, 1'b1, 12'h105, 8'h00);
            core_req(15, 1'b1, 12'h10F, 8'h00);
            expect_ev("rr_c0",  1'b0, 16'h0001, 8'hA0, 1'b1, 2);
            expect_ev("rr_c5",  1'b0, 16'h0020, 8'hA5, 1'b1, 5);
            expect_ev("rr_c15", 1'b0, 16'h8000, 8'hAF, 1'b1, 8);
            drain("rr_round");
        end

        // Core 3 store then load
        core_req(3, 1'b0, 12'h040, 8'h77); expect_ev("c3_st", 1'b0, 16'h0008, 8'h00, 1'b0, 2); drain("c3_st");
        core_req(3, 1'b1, 12'h040, 8'h00); expect_ev("c3_ld", 1'b0, 16'h0008, 8'h77, 1'b1, 2); drain("c3_ld");

        // Core 2 holds its request one cycle past val_data
        hold_mask = 16'h0004;
        core_req(2, 1'b0, 12'h200, 8'h22); expect_ev("c2_hold", 1'b0, 16'h0004, 8'h00, 1'b0, 2); drain("c2_hold");
        hold_mask = '0;
        host_go(1'b0, 12'h200, 8'h00); expect_ev("c2_chk", 1'b1, '0, 8'h22, 1'b1, 2); drain("c2_chk");

        // Host and core 7 together: core first, host 3 cycles later
        core_req(7, 1'b1, 12'h105, 8'h00);
        host_go(1'b0, 12'h123, 8'h00);
        expect_ev("c7_first",  1'b0, 16'h0080, 8'hA5, 1'b1, 2);
        expect_ev("host_after", 1'b1, '0, 8'h5A, 1'b1, 5);
        drain("host_core7");

        // Reset during ACC of a store aborts the write
        host_go(1'b1, 12'h010, 8'h33); expect_ev("pre_rst", 1'b1, '0, 8'h00, 1'b0, 2); drain("pre_rst");
        core_req(1, 1'b0, 12'h010, 8'hFF);
        tick();
        reset = 1'b0;
        #1;
        mem_req_st = '0;
        check_zero("mid_reset");
        tick();
        tick();
        reset = 1'b1;
        tick();
        host_go(1'b0, 12'h010, 8'h00); expect_ev("post_rst", 1'b1, '0, 8'h33, 1'b1, 2); drain("post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
